// File: rtl/hs32_sram_pkg.sv
// hs32_sram_pkg
//   Shared definitions for the HS32 SRAM arbiter: FSM state encoding,
//   grant encoding and the default Wishbone window base.
package hs32_sram_pkg;

  localparam logic [31:0] WB_BASE_DEFAULT = 32'h3000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_WB  = 1'b1
  } gnt_t;

endpackage

// File: rtl/hs32_sram_arbiter_if.sv
// hs32_sram_arbiter_if
//   Bundles the CPU request port, the Wishbone slave port and SRAM port 0.
//   modport slave  : arbiter view (takes requests, drives acks and SRAM)
//   modport master : environment view (drives requests, models the SRAM)
//   Signals:
//     cpu_req/we/addr/wmask/dtw -> cpu_ack/dtr
//     wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i -> wbs_ack_o/dat_o
//     sram_csb0/web0/wmask0/addr0/din0 <- sram_dout0
interface hs32_sram_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [3:0]        cpu_wmask;
  logic [31:0]       cpu_dtw;
  logic              cpu_ack;
  logic [31:0]       cpu_dtr;

  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i;
  logic [31:0]       wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;

  logic              sram_csb0;
  logic              sram_web0;
  logic [3:0]        sram_wmask0;
  logic [ADDR_W-1:0] sram_addr0;
  logic [31:0]       sram_din0;
  logic [31:0]       sram_dout0;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wmask, cpu_dtw,
    output cpu_ack, cpu_dtr,
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
    input  sram_dout0
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wmask, cpu_dtw,
    input  cpu_ack, cpu_dtr,
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
    output sram_dout0
  );
endinterface

// File: rtl/hs32_rr_arb2.sv
// hs32_rr_arb2
//   Two-input round-robin grant select, purely combinational.
//   Ports:
//     req_cpu_i, req_wb_i : request lines
//     last_gnt_i          : requester granted most recently
//     gnt_valid_o         : at least one request present
//     gnt_o               : selected requester
module hs32_rr_arb2
  import hs32_sram_pkg::*;
(
  input  logic req_cpu_i,
  input  logic req_wb_i,
  input  gnt_t last_gnt_i,
  output logic gnt_valid_o,
  output gnt_t gnt_o
);

  always_comb begin
    gnt_valid_o = req_cpu_i | req_wb_i;
    gnt_o       = GNT_CPU;
    if (req_cpu_i && req_wb_i) begin
      // Tie: favour whoever did not win last time.
      gnt_o = (last_gnt_i == GNT_CPU) ? GNT_WB : GNT_CPU;
    end else if (req_wb_i) begin
      gnt_o = GNT_WB;
    end
  end

endmodule

// File: rtl/hs32_sram_arbiter.sv
// hs32_sram_arbiter
//   Shares one single-port SRAM between a CPU port and a Wishbone slave
//   window (1 KiB at WB_BASE). Every access takes a fixed 4 cycles:
//   request sampled in N, SRAM command in N+1, read data captured at the
//   end of N+2, one-cycle ack in N+3, back to idle in N+4.
//   Ports:
//     wb_clk_i : clock (rising edge)
//     wb_rst_i : synchronous active-high reset
//     bus      : CPU, Wishbone and SRAM signals (slave modport)
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting; samples requests and registers the SRAM command
//   ST_ISSUE | SRAM command on the pins for exactly this cycle
//   ST_WAIT  | SRAM returns data; captured into the winner's dtr on reads
//   ST_DONE  | winner's ack high for this one cycle
module hs32_sram_arbiter
  import hs32_sram_pkg::*;
#(
  parameter logic [31:0] WB_BASE = WB_BASE_DEFAULT,
  parameter int          ADDR_W  = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  hs32_sram_arbiter_if.slave  bus
);

  state_t            state_q, state_d;
  gnt_t              gnt_q, gnt_d;
  gnt_t              last_gnt_q, last_gnt_d;
  logic              rd_q, rd_d;
  logic              csb_q, csb_d;
  logic              web_q, web_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              wb_ack_q, wb_ack_d;
  logic [31:0]       cpu_dtr_q, cpu_dtr_d;
  logic [31:0]       wb_dtr_q, wb_dtr_d;

  logic              wb_hit;
  logic [ADDR_W-1:0] wb_word;
  logic              gnt_valid;
  gnt_t              gnt;

  // Byte-offset bits of the Wishbone address carry no information here.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^bus.wbs_adr_i[1:0];

  assign wb_hit  = bus.wbs_cyc_i & bus.wbs_stb_i &
                   (bus.wbs_adr_i[31:10] == WB_BASE[31:10]);
  assign wb_word = bus.wbs_adr_i[ADDR_W+1:2];

  hs32_rr_arb2 u_arb (
    .req_cpu_i   (bus.cpu_req),
    .req_wb_i    (wb_hit),
    .last_gnt_i  (last_gnt_q),
    .gnt_valid_o (gnt_valid),
    .gnt_o       (gnt)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    rd_d       = rd_q;
    csb_d      = 1'b1;
    web_d      = 1'b1;
    wmask_d    = wmask_q;
    addr_d     = addr_q;
    din_d      = din_q;
    cpu_ack_d  = 1'b0;
    wb_ack_d   = 1'b0;
    cpu_dtr_d  = cpu_dtr_q;
    wb_dtr_d   = wb_dtr_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d    = ST_ISSUE;
          gnt_d      = gnt;
          last_gnt_d = gnt;
          csb_d      = 1'b0;
          if (gnt == GNT_CPU) begin
            rd_d    = ~bus.cpu_we;
            web_d   = ~bus.cpu_we;
            wmask_d = bus.cpu_wmask;
            addr_d  = bus.cpu_addr;
            din_d   = bus.cpu_dtw;
          end else begin
            rd_d    = ~bus.wbs_we_i;
            web_d   = ~bus.wbs_we_i;
            wmask_d = bus.wbs_sel_i;
            addr_d  = wb_word;
            din_d   = bus.wbs_dat_i;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        state_d = ST_DONE;
        if (rd_q) begin
          if (gnt_q == GNT_CPU) cpu_dtr_d = bus.sram_dout0;
          else                  wb_dtr_d  = bus.sram_dout0;
        end
        // Ack is registered, so raising it here makes it visible in DONE.
        if (gnt_q == GNT_CPU) cpu_ack_d = 1'b1;
        else                  wb_ack_d  = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      gnt_q      <= GNT_WB;
      last_gnt_q <= GNT_WB;
      rd_q       <= 1'b0;
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      wmask_q    <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      cpu_ack_q  <= 1'b0;
      wb_ack_q   <= 1'b0;
      cpu_dtr_q  <= '0;
      wb_dtr_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      rd_q       <= rd_d;
      csb_q      <= csb_d;
      web_q      <= web_d;
      wmask_q    <= wmask_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      cpu_ack_q  <= cpu_ack_d;
      wb_ack_q   <= wb_ack_d;
      cpu_dtr_q  <= cpu_dtr_d;
      wb_dtr_q   <= wb_dtr_d;
    end
  end

  assign bus.sram_csb0   = csb_q;
  assign bus.sram_web0   = web_q;
  assign bus.sram_wmask0 = wmask_q;
  assign bus.sram_addr0  = addr_q;
  assign bus.sram_din0   = din_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.cpu_dtr     = cpu_dtr_q;
  assign bus.wbs_ack_o   = wb_ack_q;
  assign bus.wbs_dat_o   = wb_dtr_q;

endmodule

// File: tb/tb_hs32_sram_arbiter.sv
// tb_hs32_sram_arbiter
//   Scoreboard bench: each access pushes its expected ack owner and read
//   data; acks pop and compare. A behavioural SRAM answers the DUT.
module tb_hs32_sram_arbiter;
  import hs32_sram_pkg::*;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_WB  = 1'b1;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hs32_sram_arbiter_if #(.ADDR_W(8)) bus ();

  hs32_sram_arbiter #(.WB_BASE(32'h3000_0000), .ADDR_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  logic [31:0] mem [256];
  logic [31:0] sram_q = '0;
  assign bus.sram_dout0 = sram_q;

  always @(posedge clk) begin
    if (!bus.sram_csb0) begin
      if (!bus.sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_wmask0[b]) mem[bus.sram_addr0][b*8 +: 8] <= bus.sram_din0[b*8 +: 8];
      end else begin
        sram_q <= mem[bus.sram_addr0];
      end
    end
  end

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic idle_inputs();
    bus.cpu_req   = 1'b0; bus.cpu_we   = 1'b0; bus.cpu_addr  = '0;
    bus.cpu_wmask = 4'h0; bus.cpu_dtw  = '0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0;  bus.wbs_dat_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.sram_csb0 !== 1'b1 || bus.sram_web0 !== 1'b1) begin
      errors++; $display("FAIL reset_csb_web: got %b/%b expected 1/1", bus.sram_csb0, bus.sram_web0);
    end
    checks++;
    if (bus.sram_wmask0 !== 4'h0 || bus.sram_addr0 !== 8'h00 || bus.sram_din0 !== 32'h0) begin
      errors++; $display("FAIL reset_cmd: got wmask=%h addr=%h din=%h expected 0", bus.sram_wmask0, bus.sram_addr0, bus.sram_din0);
    end
    checks++;
    if (bus.cpu_ack !== 1'b0 || bus.wbs_ack_o !== 1'b0) begin
      errors++; $display("FAIL reset_ack: got %b/%b expected 0/0", bus.cpu_ack, bus.wbs_ack_o);
    end
    checks++;
    if (bus.cpu_dtr !== 32'h0 || bus.wbs_dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_dtr: got %h/%h expected 0/0", bus.cpu_dtr, bus.wbs_dat_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    exp_t e;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10; bus.cpu_wmask = 4'hF;
    exp_q.push_back('{port: PORT_CPU, data: 32'hDEADBEEF});
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (bus.sram_csb0 !== 1'b0 || bus.sram_web0 !== 1'b1 || bus.sram_addr0 !== 8'h10) begin
          errors++; $display("FAIL cpu_read_issue: got csb0=%b web0=%b addr0=%h expected 0/1/10", bus.sram_csb0, bus.sram_web0, bus.sram_addr0);
        end
      end
      if (c == 2) begin
        checks++;
        if (bus.sram_csb0 !== 1'b1 || bus.sram_web0 !== 1'b1) begin
          errors++; $display("FAIL cpu_read_wait_csb: got %b/%b expected 1/1", bus.sram_csb0, bus.sram_web0);
        end
      end
      checks++;
      if (bus.cpu_ack !== (c == 3) || bus.wbs_ack_o !== 1'b0) begin
        errors++; $display("FAIL cpu_read_ack c%0d: got cpu=%b wb=%b expected %b/0", c, bus.cpu_ack, bus.wbs_ack_o, (c == 3));
      end
      if (c == 3 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.cpu_dtr !== e.data) begin
          errors++; $display("FAIL cpu_read_data: got %h expected %h", bus.cpu_dtr, e.data);
        end
        bus.cpu_req = 1'b0;
      end
      if (c == 5) begin
        checks++;
        if (bus.cpu_dtr !== 32'hDEADBEEF) begin
          errors++; $display("FAIL cpu_dtr_hold: got %h expected deadbeef", bus.cpu_dtr);
        end
      end
    end
  endtask

  task automatic test_wb_write();
    exp_t e;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 32'h3000_0040; bus.wbs_dat_i = 32'h1234_5678; bus.wbs_sel_i = 4'b0101;
    exp_q.push_back('{port: PORT_WB, data: 32'hDE34_BE78});
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (bus.sram_csb0 !== 1'b0 || bus.sram_web0 !== 1'b0 || bus.sram_addr0 !== 8'h10 ||
            bus.sram_wmask0 !== 4'b0101 || bus.sram_din0 !== 32'h1234_5678) begin
          errors++; $display("FAIL wb_write_issue: got csb0=%b web0=%b addr0=%h wmask0=%b din0=%h expected 0/0/10/0101/12345678",
                             bus.sram_csb0, bus.sram_web0, bus.sram_addr0, bus.sram_wmask0, bus.sram_din0);
        end
      end
      checks++;
      if (bus.wbs_ack_o !== (c == 3) || bus.cpu_ack !== 1'b0) begin
        errors++; $display("FAIL wb_write_ack c%0d: got wb=%b cpu=%b expected %b/0", c, bus.wbs_ack_o, bus.cpu_ack, (c == 3));
      end
      if (c == 3) begin
        idle_inputs();
      end
      if (c == 5 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (mem[8'h10] !== e.data || bus.wbs_dat_o !== 32'h0) begin
          errors++; $display("FAIL wb_write_result: got mem=%h dat_o=%h expected %h/0", mem[8'h10], bus.wbs_dat_o, e.data);
        end
      end
    end
  endtask

  task automatic test_wb_miss();
    int bad = 0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h3000_0400; bus.wbs_sel_i = 4'hF;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.sram_csb0 !== 1'b1 || bus.wbs_ack_o !== 1'b0 || bus.cpu_ack !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wb_miss: got %0d active cycles expected 0", bad);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic ack_cyc;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h01;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h3000_0008; bus.wbs_sel_i = 4'hF;
    exp_q.push_back('{port: PORT_CPU, data: 32'h1111_1111});
    exp_q.push_back('{port: PORT_WB,  data: 32'h2222_2222});
    exp_q.push_back('{port: PORT_CPU, data: 32'h1111_1111});
    exp_q.push_back('{port: PORT_WB,  data: 32'h2222_2222});
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      ack_cyc = (c % 4 == 3) && (exp_q.size() > 0);
      e = '{port: PORT_CPU, data: 32'h0};
      if (ack_cyc) e = exp_q.pop_front();
      checks++;
      if (bus.cpu_ack !== (ack_cyc && e.port == PORT_CPU) || bus.wbs_ack_o !== (ack_cyc && e.port == PORT_WB)) begin
        errors++; $display("FAIL rr_ack c%0d: got cpu=%b wb=%b expected %b/%b", c, bus.cpu_ack, bus.wbs_ack_o,
                           (ack_cyc && e.port == PORT_CPU), (ack_cyc && e.port == PORT_WB));
      end
      if (ack_cyc) begin
        checks++;
        if ((e.port == PORT_CPU ? bus.cpu_dtr : bus.wbs_dat_o) !== e.data) begin
          errors++; $display("FAIL rr_data c%0d: got cpu=%h wb=%h expected %h on port %0d", c, bus.cpu_dtr, bus.wbs_dat_o, e.data, e.port);
        end
      end
      if (c == 15) idle_inputs();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rr_pending: got %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        checks++;
        if (dut.state_q !== ST_IDLE || bus.sram_csb0 !== 1'b1 || bus.cpu_ack !== 1'b0 ||
            bus.cpu_dtr !== 32'h0 || bus.wbs_dat_o !== 32'h0) begin
          errors++; $display("FAIL reset_mid: got state=%0d csb0=%b ack=%b dtr=%h/%h expected 0/1/0/0/0",
                             dut.state_q, bus.sram_csb0, bus.cpu_ack, bus.cpu_dtr, bus.wbs_dat_o);
        end
        rst = 1'b0;
        bus.cpu_req = 1'b0;
      end
      if (c > 3 && (bus.cpu_ack !== 1'b0 || bus.wbs_ack_o !== 1'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_mid_noack: got %0d ack cycles expected 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int acks = 0;
    int issues = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
    repeat (3) exp_q.push_back('{port: PORT_CPU, data: 32'hDE34_BE78});
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (bus.sram_csb0 === 1'b0) begin
        issues++;
        checks++;
        if (c % 4 != 1) begin
          errors++; $display("FAIL b2b_issue_cycle: got issue at c%0d expected only c%%4==1", c);
        end
      end
      if (bus.cpu_ack === 1'b1) begin
        acks++;
        checks++;
        if (exp_q.size() == 0 || c % 4 != 3) begin
          errors++; $display("FAIL b2b_ack_cycle: got ack at c%0d with %0d pending expected c%%4==3", c, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          if (bus.cpu_dtr !== e.data) begin
            errors++; $display("FAIL b2b_data: got %h expected %h", bus.cpu_dtr, e.data);
          end
        end
      end
      if (c == 12) bus.cpu_req = 1'b0;
    end
    checks++;
    if (acks != 3 || issues != 3) begin
      errors++; $display("FAIL b2b_counts: got acks=%0d issues=%0d expected 3/3", acks, issues);
    end
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h01] = 32'h1111_1111;
    mem[8'h02] = 32'h2222_2222;
    mem[8'h10] = 32'hDEAD_BEEF;
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_wb_write();
    test_wb_miss();
    test_round_robin();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs32_sram_arbiter.md
HS32_SRAM_ARBITER -- requirements
Module: hs32_sram_arbiter

Interface
REQ-001 Parameter WB_BASE, default 32'h3000_0000: Wishbone window base; window is 1 KiB.
REQ-002 Parameter ADDR_W, default 8: SRAM word-address width.
REQ-003 The clock SHALL be wb_clk_i (input, 1): single clock; all state SHALL be clocked on its rising edge.
REQ-004 The reset SHALL be wb_rst_i (input, 1): synchronous, active-high.
REQ-005 CPU port SHALL be:
- cpu_req (in, 1)
- cpu_we (in, 1)
- cpu_addr (in, ADDR_W): word address
- cpu_wmask (in, 4)
- cpu_dtw (in, 32)
- cpu_ack (out, 1)
- cpu_dtr (out, 32)
REQ-006 Wishbone slave port SHALL be:
- wbs_cyc_i, wbs_stb_i, wbs_we_i (in, 1 each)
- wbs_sel_i (in, 4)
- wbs_adr_i, wbs_dat_i (in, 32 each)
- wbs_ack_o (out, 1)
- wbs_dat_o (out, 32)
REQ-007 SRAM port 0 SHALL be:
- sram_csb0 (out, 1): active-low chip select
- sram_web0 (out, 1): active-low write enable
- sram_wmask0 (out, 4)
- sram_addr0 (out, ADDR_W)
- sram_din0 (out, 32)
- sram_dout0 (in, 32)

Function
REQ-008 Wishbone hit SHALL be: wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:10] == WB_BASE[31:10]); word address = wbs_adr_i[ADDR_W+1:2].
REQ-009 A Wishbone miss SHALL never be acked or serviced.
REQ-010 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, DONE.
REQ-011 In IDLE with at least one request, the arbiter SHALL grant one requester and register the SRAM command, then go to ISSUE.
- Command: csb0=0; web0=~we; wmask = cpu_wmask or wbs_sel_i; addr; din.
REQ-012 The registered SRAM command SHALL be held for exactly the ISSUE cycle; from WAIT onward csb0=1 and web0=1.
REQ-013 In WAIT, the arbiter SHALL capture sram_dout0 into the granted requester's read-data register on reads only; writes leave it unchanged. Next state is DONE.
REQ-014 In DONE, the arbiter SHALL pulse the granted requester's ack for exactly one cycle, then return to IDLE.
REQ-015 Latency SHALL be fixed: request sampled in cycle N -> ack in cycle N+3 -> IDLE in cycle N+4. Throughput is one access per 4 cycles.
REQ-016 Requests SHALL NOT be sampled in ISSUE, WAIT or DONE, so a request still held high during its ack cycle is not serviced twice.
REQ-017 Arbitration SHALL be:
- Single requester: that requester is granted.
- Simultaneous CPU and WB requests: round-robin, granting the requester not granted last.
- The last-grant bit resets to WB, so CPU wins the first tie.
REQ-018 Requesters SHALL hold request and all fields stable until ack; fields are sampled only in IDLE.
REQ-019 cpu_dtr and wbs_dat_o SHALL be registers that hold their last read value between accesses.
REQ-020 Dropping a request after it has been granted SHALL NOT abort the access; it completes and the ack is still pulsed.

Reset
REQ-021 On wb_rst_i, the following SHALL be set next edge regardless of state:
- state=IDLE
- sram_csb0=1, sram_web0=1
- sram_wmask0, sram_addr0, sram_din0 = 0
- cpu_ack=0, wbs_ack_o=0
- cpu_dtr, wbs_dat_o = 0
- last grant = WB
REQ-022 Reset asserted mid-access SHALL cancel it with no ack; an SRAM write already issued may have completed.

Structure
REQ-023 Shared package hs32_sram_pkg SHALL hold: state encoding, the WB_BASE default, and the grant encoding (GNT_CPU, GNT_WB).
REQ-024 One sub-module, hs32_rr_arb2 (2-input round-robin, combinational, last-grant input), SHALL perform the grant selection.

Verification
REQ-025 CPU read, addr 8'h10, sram_dout0=32'hDEADBEEF in WAIT -> csb0=0/web0=1 in cycle N+1; cpu_ack high only in N+3 with cpu_dtr=32'hDEADBEEF.
REQ-026 WB write, adr 32'h3000_0040, dat 32'h12345678, sel 4'b0101 -> sram_addr0=8'h10, wmask0=4'b0101, web0=0 in N+1; wbs_ack_o pulse in N+3; cpu_ack stays 0.
REQ-027 CPU and WB request in the same cycle, both held, after reset -> grant order CPU, WB, CPU, WB; ack every 4 cycles.
REQ-028 WB access to adr 32'h3000_0400 -> no csb0 assertion and no wbs_ack_o for 20 cycles.
REQ-029 wb_rst_i asserted in the WAIT cycle -> next cycle state IDLE, csb0=1, no ack pulse, dtr registers=0.
REQ-030 cpu_req held high continuously for 12 cycles -> exactly 3 acks, no duplicate SRAM issue during DONE.
